// File: rtl/fp_div_seq_if.sv
// ---------------------------------------------------------------------------
// fp_div_seq_if
// Operand/result bundle for the sequential floating-point divider.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and the payload stable until that
// edge. The consumer may raise or lower ready freely.
//
// Signals (W = 1 + EXP_W + MAN_W)
//   in_valid   producer -> divider   operands/rm valid
//   in_ready   divider  -> producer  divider can accept a new operation
//   a, b       producer -> divider   dividend, divisor (W bits)
//   rm         producer -> divider   rounding mode (3 bits)
//   out_valid  divider  -> consumer  y/exc_flags valid, held until accepted
//   out_ready  consumer -> divider   consumer accepts the result
//   y          divider  -> consumer  quotient (W bits)
//   exc_flags  divider  -> consumer  {invalid, divzero, overflow, underflow, inexact}
//
// Modports: slave = divider side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface fp_div_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [4:0]   exc_flags;

    modport slave (
        input  in_valid, a, b, rm, out_ready,
        output in_ready, out_valid, y, exc_flags
    );

    modport master (
        output in_valid, a, b, rm, out_ready,
        input  in_ready, out_valid, y, exc_flags
    );
endinterface

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq
// Multi-cycle IEEE-754 divider (default binary32) with five dynamic rounding
// modes. One radix-2 restoring quotient bit is produced per cycle.
// One operation in flight; valid/ready on both sides (see fp_div_seq_if).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, returns to IDLE from any state
//   bus          fp_div_seq_if.slave (operands, rm, result, flags, handshakes)
//   o_dbg_state  current FSM state (0 IDLE, 1 PREP, 2 DIV, 3 ROUND, 4 DONE)
//
// rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others behave as RNE.
//
// Configuration macro: FP_DIV_SEQ_FTZ_EN
//   defined   -> subnormal inputs read as signed zero, tiny results flush to
//                signed zero with underflow+inexact, no subnormal shifter.
//   undefined -> full gradual underflow.
// ---------------------------------------------------------------------------
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    fp_div_seq_if.slave       bus,
    output logic [2:0]        o_dbg_state
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int Q   = MAN_W + 3;
    localparam int EW  = EXP_W + 3;
    localparam int CW  = $clog2(Q);
    localparam int LZW = $clog2(MAN_W + 2);

    localparam logic [EW-1:0]        BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_MAX  = EW'(2 ** EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV   = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_next;
    logic   w_in_ready, w_out_valid;

    // Registered operation
    logic [W-1:0]            r_a, r_b;
    logic [2:0]              r_rm;
    logic                    r_sign;
    logic                    r_special;
    logic [W-1:0]            r_sp_y;
    logic [4:0]              r_sp_f;
    logic signed [EW-1:0]    r_exp;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W:0]          r_div;
    logic [Q-1:0]            r_q;
    logic [CW-1:0]           r_cnt;
    logic [W-1:0]            r_y;
    logic [4:0]              r_flags;

    // Round-to-increment decision for one significand position.
    function automatic logic rnd_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
        case (rm)
            3'b001:  return 1'b0;
            3'b010:  return sign & (g | s);
            3'b011:  return ~sign & (g | s);
            3'b100:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

`ifndef FP_DIV_SEQ_FTZ_EN
    function automatic logic [LZW-1:0] lzc(input logic [MAN_W:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 1'b1;
            end
        end
        return n;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Operand decode (valid while in PREP)
    // ------------------------------------------------------------------
    logic               w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]   w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [MAN_W-1:0]   w_fa, w_fb;
    logic               w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic               w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [MAN_W:0]     w_ma, w_mb, w_na, w_nb;
    logic [LZW-1:0]     w_lza, w_lzb;
    logic [EW-1:0]      w_exp;

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1];
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_sign   = w_sa ^ w_sb;
    assign w_a_nan  = (&w_ea) & (|w_fa);
    assign w_b_nan  = (&w_eb) & (|w_fb);
    assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_ma     = {|w_ea, w_fa};
    assign w_mb     = {|w_eb, w_fb};
    // A zero exponent field encodes the same scale as exponent 1.
    assign w_ea_eff = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eb_eff = (w_eb == '0) ? EXP_W'(1) : w_eb;

`ifdef FP_DIV_SEQ_FTZ_EN
    assign w_a_zero = ~(|w_ea);
    assign w_b_zero = ~(|w_eb);
    assign w_lza    = '0;
    assign w_lzb    = '0;
`else
    assign w_a_zero = ~(|w_ea) & ~(|w_fa);
    assign w_b_zero = ~(|w_eb) & ~(|w_fb);
    assign w_lza    = lzc(w_ma);
    assign w_lzb    = lzc(w_mb);
`endif

    assign w_na  = w_ma << w_lza;
    assign w_nb  = w_mb << w_lzb;
    assign w_exp = {3'b000, w_ea_eff} - {3'b000, w_eb_eff} + BIAS_E
                 - {{(EW-LZW){1'b0}}, w_lza} + {{(EW-LZW){1'b0}}, w_lzb};

    logic         w_special;
    logic [W-1:0] w_sp_y;
    logic [4:0]   w_sp_f;

    always_comb begin
        w_special = 1'b1;
        w_sp_y    = '0;
        w_sp_f    = '0;
        if (w_a_nan || w_b_nan) begin
            w_sp_y    = QNAN;
            w_sp_f[4] = w_a_snan | w_b_snan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_sp_y    = QNAN;
            w_sp_f[4] = 1'b1;
        end else if (w_a_inf) begin
            w_sp_y = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_sp_y    = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_sp_f[3] = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_sp_y = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Restoring divide step
    // ------------------------------------------------------------------
    logic             w_ge;
    logic [MAN_W:0]   w_diff;
    logic [MAN_W+1:0] w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    // When w_ge holds the difference is below the divisor, so MAN_W+1 bits suffice.
    assign w_diff    = r_rem[MAN_W:0] - r_div;
    assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[MAN_W:0], 1'b0};

    // ------------------------------------------------------------------
    // Normalise / round / pack (valid while in ROUND)
    // ------------------------------------------------------------------
    logic                 w_msb, w_g, w_s, w_inc_n, w_carry_n, w_ovf, w_ovf_inf, w_tiny, w_nx_n;
    logic [MAN_W:0]       w_m;
    logic [MAN_W+1:0]     w_mr_n;
    logic signed [EW-1:0] w_e, w_e_n;
    logic [W-1:0]         w_res_y;
    logic [4:0]           w_res_f;

`ifndef FP_DIV_SEQ_FTZ_EN
    localparam int SH_MAX = Q + 2;
    localparam int SHW    = $clog2(SH_MAX + 1);
    localparam int XW     = MAN_W + 2 + SH_MAX;
    localparam logic signed [EW-1:0] SH_MAX_E = EW'(SH_MAX);

    logic signed [EW-1:0] w_sh;
    logic [SHW-1:0]       w_sh_amt;
    logic [XW-1:0]        w_ext;
    logic [MAN_W+1:0]     w_kept;
    logic [MAN_W:0]       w_m_s, w_mr_s;
    logic                 w_g_s, w_s_s, w_inc_s, w_nx_s;
`endif

    always_comb begin
        // A quotient below 1 needs one left shift; the spare low bit covers it.
        w_msb     = r_q[Q-1];
        w_m       = w_msb ? r_q[Q-1:2] : r_q[Q-2:1];
        w_g       = w_msb ? r_q[1] : r_q[0];
        w_s       = (w_msb & r_q[0]) | (|r_rem);
        w_e       = w_msb ? r_exp : r_exp - E_ONE;
        w_nx_n    = w_g | w_s;
        w_inc_n   = rnd_inc(r_rm, r_sign, w_m[0], w_g, w_s);
        w_mr_n    = {1'b0, w_m} + {{(MAN_W+1){1'b0}}, w_inc_n};
        w_carry_n = w_mr_n[MAN_W+1];
        w_e_n     = w_e + {{(EW-1){1'b0}}, w_carry_n};
        w_ovf     = (w_e_n >= E_MAX);
        case (r_rm)
            3'b001:  w_ovf_inf = 1'b0;
            3'b010:  w_ovf_inf = r_sign;
            3'b011:  w_ovf_inf = ~r_sign;
            default: w_ovf_inf = 1'b1;
        endcase
        // Tiny after rounding: below min normal even with unbounded exponent.
        w_tiny = (w_e < E_ONE) && !((w_e == E_ZERO) && w_carry_n);

`ifndef FP_DIV_SEQ_FTZ_EN
        w_sh     = E_ONE - w_e;
        w_sh_amt = (w_sh > SH_MAX_E) ? SHW'(SH_MAX) : w_sh[SHW-1:0];
        w_ext    = {w_m, w_g, {SH_MAX{1'b0}}} >> w_sh_amt;
        w_kept   = w_ext[XW-1 -: MAN_W+2];
        w_m_s    = w_kept[MAN_W+1:1];
        w_g_s    = w_kept[0];
        w_s_s    = w_s | (|w_ext[SH_MAX-1:0]);
        w_nx_s   = w_g_s | w_s_s;
        w_inc_s  = rnd_inc(r_rm, r_sign, w_m_s[0], w_g_s, w_s_s);
        w_mr_s   = w_m_s + {{MAN_W{1'b0}}, w_inc_s};
`endif

        w_res_y = '0;
        w_res_f = '0;
        if (w_ovf) begin
            w_res_y = w_ovf_inf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                : {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            w_res_f = 5'b00101;
`ifdef FP_DIV_SEQ_FTZ_EN
        end else if (w_tiny) begin
            w_res_y = {r_sign, {(W-1){1'b0}}};
            w_res_f = 5'b00011;
`else
        end else if (w_e < E_ONE) begin
            // Carry into bit MAN_W of w_mr_s lands in the exponent LSB (min normal).
            w_res_y = {r_sign, {(EXP_W-1){1'b0}}, w_mr_s};
            w_res_f = {3'b000, w_tiny & w_nx_s, w_nx_s};
`endif
        end else begin
            w_res_y = {r_sign, w_e_n[EXP_W-1:0],
                       w_carry_n ? w_mr_n[MAN_W:1] : w_mr_n[MAN_W-1:0]};
            w_res_f = {4'b0000, w_nx_n};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Specials skip DIV; ROUND then only selects the precomputed result.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_PREP;
            end
            S_PREP:  w_next = w_special ? S_ROUND : S_DIV;
            S_DIV:   if (r_cnt == '0) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        r_rm <= bus.rm;
                    end
                end
                S_PREP: begin
                    r_sign    <= w_sign;
                    r_special <= w_special;
                    r_sp_y    <= w_sp_y;
                    r_sp_f    <= w_sp_f;
                    r_exp     <= w_exp;
                    r_rem     <= {1'b0, w_na};
                    r_div     <= w_nb;
                    r_q       <= '0;
                    r_cnt     <= CW'(Q - 1);
                end
                S_DIV: begin
                    r_q   <= {r_q[Q-2:0], w_ge};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    r_y     <= r_special ? r_sp_y : w_res_y;
                    r_flags <= r_special ? r_sp_f : w_res_f;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_y;
    assign bus.exc_flags = r_flags;
    assign o_dbg_state   = r_state;
endmodule
